// File: rtl/gpu_pkg.sv
// Shared constants for the GPU data-memory path.
package gpu_pkg;

  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_DATA_W = 64;
  localparam int unsigned STAT_W      = 16;

  // Width of a binary requester index; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick. Searches req from index ptr
// upward with wrap and returns a one-hot grant plus its binary index.
module rr_pick
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               valid
);

  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] pos;

  // Rotate by ptr, take the first set bit, map back to a requester index.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // ptr < NUM_REQ and k < NUM_REQ, so one conditional subtract wraps.
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      pos = sum[PTR_W-1:0];
      if (!valid && req[pos]) begin
        valid    = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter: round-robin sharing of one single-port data-memory BRAM.
// Grants one requester per cycle, registers the BRAM command and steers the
// registered read data back via a two-stage {valid, index} return pipe.
// Optional wait-cycle statistics: define DMEM_ARB_STATS_EN.
module dmem_rr_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = DMEM_ADDR_W,
  parameter int unsigned DATA_W  = DMEM_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [NUM_REQ*STAT_W-1:0] stat_wait
`endif
);

  localparam int unsigned    PTR_W    = ptr_width(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] req_live;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;

  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  logic [PTR_W-1:0]   ptr_d, ptr_q;
  logic               mem_en_d, mem_en_q;
  logic               mem_we_d, mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_d, mem_wdata_q;
  logic               s1_vld_d, s1_vld_q;
  logic [PTR_W-1:0]   s1_idx_d, s1_idx_q;
  logic               s2_vld_d, s2_vld_q;
  logic [PTR_W-1:0]   s2_idx_d, s2_idx_q;

  // No requester is visible to the picker while reset is held.
  assign req_live = rst ? '0 : req;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req   (req_live),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign gnt = pick_gnt;

  // One-hot AND-OR mux of the granted requester's command fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next pointer, next BRAM command and return-pipe advance.
  always_comb begin
    ptr_d       = ptr_q;
    mem_en_d    = pick_valid;
    mem_we_d    = pick_valid & sel_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (pick_valid) begin
      ptr_d       = (pick_idx == PTR_LAST) ? '0 : pick_idx + PTR_W'(1);
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
    end
    s1_vld_d = pick_valid & ~sel_we;
    s1_idx_d = pick_idx;
    s2_vld_d = s1_vld_q;
    s2_idx_d = s1_idx_q;
  end

  // Pointer, command and return-pipe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_idx_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      s1_vld_q    <= s1_vld_d;
      s1_idx_q    <= s1_idx_d;
      s2_vld_q    <= s2_vld_d;
      s2_idx_q    <= s2_idx_d;
    end
  end

  // A command already registered when reset arrives is squashed, so an
  // in-flight store never reaches the BRAM during reset.
  assign mem_en    = mem_en_q & ~rst;
  assign mem_we    = mem_we_q & ~rst;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = mem_rdata;

  // Decode the stage-2 return slot to a one-hot load-valid.
  always_comb begin
    rvalid = '0;
    if (s2_vld_q && !rst) begin
      rvalid[s2_idx_q] = 1'b1;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] wait_d, wait_q;

  // Saturating per-requester wait counters; clear wins over increment.
  always_comb begin
    wait_d = wait_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (stat_clr) begin
        wait_d[i] = '0;
      end else if (req[i] && !gnt[i] && (wait_q[i] != '1)) begin
        wait_d[i] = wait_q[i] + STAT_W'(1);
      end
    end
  end

  // Wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign stat_wait = wait_q;
`endif

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Self-checking bench for dmem_rr_arbiter with a write-first BRAM model.
module tb_dmem_rr_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   req_we;
  logic [31:0]  req_addr;
  logic [255:0] req_wdata;
  logic [3:0]   gnt;
  logic [3:0]   rvalid;
  logic [63:0]  rdata;
  logic         mem_en;
  logic         mem_we;
  logic [7:0]   mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic         stat_clr;
  logic [63:0]  stat_wait;
`endif

  dmem_rr_arbiter #(
    .NUM_REQ (4),
    .ADDR_W  (8),
    .DATA_W  (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_wait (stat_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: registered read, write-first, plus a preload port.
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [63:0] pl_data;
  logic [63:0] bram [256];
  logic [63:0] bram_q;
  always @(posedge clk) begin
    if (pl_we) begin
      bram[pl_addr] <= pl_data;
    end else if (mem_en) begin
      if (mem_we) begin
        bram[mem_addr] <= mem_wdata;
        bram_q         <= mem_wdata;
      end else begin
        bram_q <= bram[mem_addr];
      end
    end
  end
  assign mem_rdata = bram_q;

  typedef struct {
    int          idx;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] ref_mem [256];
  int          m_ptr = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle scoreboard at the negedge: expected grant from a reference
  // round-robin model, pop due load returns, push newly granted loads.
  task automatic step();
    logic [3:0] eg;
    logic [3:0] ev;
    logic [7:0] a;
    int         gi;
    int         j;
    @(negedge clk);
    eg = '0;
    gi = -1;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (gi < 0 && req[j]) begin
          gi    = j;
          eg[j] = 1'b1;
        end
      end
    end
    n_checks++;
    if (gnt !== eg) begin
      n_fail++;
      $display("FAIL sb_gnt: gnt=%b expected %b at cycle %0d", gnt, eg, cyc);
    end
    if (rst) begin
      n_checks++;
      if (rvalid !== 4'b0000) begin
        n_fail++;
        $display("FAIL sb_rvalid_rst: rvalid=%b expected 0000 at cycle %0d", rvalid, cyc);
      end
      sbq.delete();
      m_ptr = 0;
    end else begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        ev = '0;
        ev[sbq[0].idx] = 1'b1;
        n_checks++;
        if (rvalid !== ev) begin
          n_fail++;
          $display("FAIL sb_rvalid: rvalid=%b expected %b at cycle %0d", rvalid, ev, cyc);
        end
        n_checks++;
        if (rdata !== sbq[0].data) begin
          n_fail++;
          $display("FAIL sb_rdata: rdata=%h expected %h at cycle %0d", rdata, sbq[0].data, cyc);
        end
        void'(sbq.pop_front());
      end else begin
        n_checks++;
        if (rvalid !== 4'b0000) begin
          n_fail++;
          $display("FAIL sb_rvalid_idle: rvalid=%b expected 0000 at cycle %0d", rvalid, cyc);
        end
      end
      if (gi >= 0) begin
        a = req_addr[gi*8 +: 8];
        if (req_we[gi]) begin
          ref_mem[a] = req_wdata[gi*64 +: 64];
        end else begin
          sbq.push_back('{idx: gi, data: ref_mem[a], due: cyc + 2});
        end
        m_ptr = (gi + 1) % 4;
      end
    end
  endtask

  task automatic set_slot(input int i, input logic we, input logic [7:0] a, input logic [63:0] d);
    req[i]              = 1'b1;
    req_we[i]           = we;
    req_addr[i*8 +: 8]  = a;
    req_wdata[i*64 +: 64] = d;
  endtask

  task automatic clear_reqs();
    req    = '0;
    req_we = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [63:0] d);
    pl_we      = 1'b1;
    pl_addr    = a;
    pl_data    = d;
    ref_mem[a] = d;
    step();
    tick();
    pl_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    step();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    step();
    n_checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mem_ctl: en=%b we=%b expected 0 0", mem_en, mem_we);
    end
    n_checks++;
    if (mem_addr !== 8'h00 || mem_wdata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (gnt !== 4'b0000 || mem_en !== 1'b0 || rvalid !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_quiet: gnt=%b mem_en=%b rvalid=%b expected 0000 0 0000", gnt, mem_en, rvalid);
      end
      tick();
    end
  endtask

  task automatic test_single_load();
    do_reset();
    set_slot(2, 1'b0, 8'h10, 64'h0);
    step();
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_gnt: gnt=%b expected 0100", gnt);
    end
    tick();
    clear_reqs();
    step();
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin
      n_fail++;
      $display("FAIL single_cmd: en=%b we=%b addr=%h expected 1 0 10", mem_en, mem_we, mem_addr);
    end
    tick();
    step();
    n_checks++;
    if (rvalid !== 4'b0100 || rdata !== 64'hDEAD_BEEF_0000_0001) begin
      n_fail++;
      $display("FAIL single_ret: rvalid=%b rdata=%h expected 0100 deadbeef00000001", rvalid, rdata);
    end
    tick();
    idle(2);
  endtask

  task automatic test_all_four();
    logic [3:0] eg;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_slot(i, 1'b0, 8'(i), 64'h0);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      eg = 4'(1 << (k % 4));
      n_checks++;
      if (gnt !== eg) begin
        n_fail++;
        $display("FAIL all4_seq[%0d]: gnt=%b expected %b", k, gnt, eg);
      end
      tick();
    end
    clear_reqs();
    step();
`ifdef DMEM_ARB_STATS_EN
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (stat_wait[i*16 +: 16] !== 16'd6) begin
        n_fail++;
        $display("FAIL stat_wait[%0d]: got %0d expected 6", i, stat_wait[i*16 +: 16]);
      end
    end
    tick();
    stat_clr = 1'b1;
    set_slot(1, 1'b0, 8'h01, 64'h0);
    set_slot(2, 1'b0, 8'h02, 64'h0);
    step();
    tick();
    stat_clr = 1'b0;
    clear_reqs();
    step();
    n_checks++;
    if (stat_wait !== 64'h0) begin
      n_fail++;
      $display("FAIL stat_clr: stat_wait=%h expected 0", stat_wait);
    end
`endif
    tick();
    idle(2);
  endtask

  task automatic test_store_load();
    do_reset();
    set_slot(3, 1'b1, 8'h20, 64'h1234);
    step();
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL st_gnt: gnt=%b expected 1000", gnt);
    end
    tick();
    clear_reqs();
    set_slot(0, 1'b0, 8'h20, 64'h0);
    step();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL ld_gnt: gnt=%b expected 0001", gnt);
    end
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 64'h1234) begin
      n_fail++;
      $display("FAIL st_cmd: en=%b we=%b addr=%h wdata=%h expected 1 1 20 1234", mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    clear_reqs();
    step();
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h20) begin
      n_fail++;
      $display("FAIL ld_cmd: en=%b we=%b addr=%h expected 1 0 20", mem_en, mem_we, mem_addr);
    end
    tick();
    step();
    n_checks++;
    if (rvalid !== 4'b0001 || rdata !== 64'h1234) begin
      n_fail++;
      $display("FAIL raw_ret: rvalid=%b rdata=%h expected 0001 1234", rvalid, rdata);
    end
    tick();
    idle(2);
  endtask

  task automatic test_wrap();
    do_reset();
    set_slot(2, 1'b0, 8'h10, 64'h0);
    step();
    tick();
    clear_reqs();
    set_slot(0, 1'b0, 8'h00, 64'h0);
    set_slot(3, 1'b0, 8'h03, 64'h0);
    step();
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_first: gnt=%b expected 1000", gnt);
    end
    tick();
    step();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_second: gnt=%b expected 0001", gnt);
    end
    tick();
    clear_reqs();
    idle(3);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_slot(1, 1'b0, 8'h01, 64'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (gnt !== 4'b0010) begin
        n_fail++;
        $display("FAIL b2b_gnt[%0d]: gnt=%b expected 0010", k, gnt);
      end
      if (k > 0) begin
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 8'h01) begin
          n_fail++;
          $display("FAIL b2b_cmd[%0d]: en=%b addr=%h expected 1 01", k, mem_en, mem_addr);
        end
      end
      tick();
    end
    clear_reqs();
    idle(3);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_slot(1, 1'b0, 8'h30, 64'h0);
    step();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL rmid_gnt: gnt=%b expected 0010", gnt);
    end
    tick();
    clear_reqs();
    rst = 1'b1;
    step();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (rvalid !== 4'b0000 || mem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_drop[%0d]: rvalid=%b mem_en=%b expected 0000 0", k, rvalid, mem_en);
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    pl_we     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
`ifdef DMEM_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    tick();
    preload(8'h10, 64'hDEAD_BEEF_0000_0001);
    preload(8'h20, 64'h0000_0000_0000_0BAD);
    preload(8'h30, 64'h3030_3030_3030_3030);
    for (int i = 0; i < 4; i++) begin
      preload(8'(i), 64'hA000_0000_0000_0000 + 64'(i));
    end
    test_reset();
    test_single_load();
    test_all_four();
    test_store_load();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    idle(3);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d returns outstanding, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
